// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the
// CPU register interface.
//   - rx_irq/rx_data      : byte-complete pulse and byte from the receiver
//   - rx_frame_err        : receiver frame-error level
//   - rx_finish           : one-cycle pulse releasing the receiver's error hold
//   - rd_en/rd_data/rd_valid : pop request, registered popped byte, valid pulse
//   - flush/clr_status    : empty the FIFO / clear sticky status
//   - thresh              : fill-level interrupt threshold (0 disables)
//   - count/empty/full    : occupancy
//   - overrun/frame_err_seen : sticky status
//   - irq_out             : registered level interrupt
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_irq,
  input  logic [7:0]    rx_data,
  input  logic          rx_frame_err,
  output logic          rx_finish,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          flush,
  input  logic          clr_status,
  input  logic [AW:0]   thresh,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overrun,
  output logic          frame_err_seen,
  output logic          irq_out
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, HOLD = 2'd2} err_st_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q;
  logic          overrun_q, overrun_d;
  logic          fes_q, fes_d;
  logic          irq_q, irq_d;
  err_st_e       st_q, st_d;

  logic push_req, push, pop, ovr_set, fe_set;

  // Datapath control. A push into a full FIFO is still accepted when a pop
  // frees a slot in the same cycle; flush overrides both.
  always_comb begin
    push_req  = rx_irq & ~rx_frame_err;
    pop       = rd_en & ~empty_q & ~flush;
    push      = push_req & ~flush & (~full_q | pop);
    ovr_set   = push_req & ~flush & full_q & ~pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Frame-error handshake: acknowledge once per error episode, then wait
  // for the receiver to drop its error level.
  always_comb begin
    st_d      = st_q;
    rx_finish = 1'b0;
    fe_set    = 1'b0;
    case (st_q)
      IDLE: if (rx_frame_err) begin
        st_d   = ACK;
        fe_set = 1'b1;
      end
      ACK: begin
        rx_finish = 1'b1;
        st_d      = HOLD;
      end
      HOLD:    if (!rx_frame_err) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Sticky bits: clear first so a same-cycle set wins. The interrupt uses
  // the current registered state, so it trails its cause by one cycle.
  always_comb begin
    overrun_d = clr_status ? 1'b0 : overrun_q;
    fes_d     = clr_status ? 1'b0 : fes_q;
    if (ovr_set) overrun_d = 1'b1;
    if (fe_set)  fes_d     = 1'b1;
    irq_d = ((thresh != '0) & (count_q >= thresh)) | overrun_q | fes_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      fes_q      <= 1'b0;
      irq_q      <= 1'b0;
      st_q       <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == FULL_CNT);
      rd_data_q  <= rd_data_d;
      rd_valid_q <= pop;
      overrun_q  <= overrun_d;
      fes_q      <= fes_d;
      irq_q      <= irq_d;
      st_q       <= st_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign count          = count_q;
  assign empty          = empty_q;
  assign full           = full_q;
  assign overrun        = overrun_q;
  assign frame_err_seen = fes_q;
  assign irq_out        = irq_q;

endmodule
